// File: rtl/fwr_pkg.sv
// Shared encodings for the frame-window read controller.
package fwr_pkg;

  localparam logic [1:0] SCALE_1X = 2'd0;
  localparam logic [1:0] SCALE_2X = 2'd1;
  localparam logic [1:0] SCALE_4X = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } fwr_state_t;

  // log2 of the upscale factor; the unused encoding behaves as 1x.
  function automatic logic [1:0] scale_shift(input logic [1:0] scale);
    case (scale)
      SCALE_2X: return 2'd1;
      SCALE_4X: return 2'd2;
      default:  return 2'd0;
    endcase
  endfunction

endpackage

// File: rtl/frame_window_reader_if.sv
// Frame-buffer read port between the window reader and the dual-port RAM.
interface frame_window_reader_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 15
);
  logic              ram_rden;
  logic [ADDR_W-1:0] ram_rdaddr;
  logic [DATA_W-1:0] ram_q;

  modport master (output ram_rden, output ram_rdaddr, input ram_q);
  modport slave  (input ram_rden, input ram_rdaddr, output ram_q);
endinterface

// File: rtl/fwr_delay.sv
// Parametrised-depth shift register used to align control with RAM data.
module fwr_delay #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] stage [DEPTH];

  // Shift one stage per clock; all stages clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) stage[i] <= '0;
    end else begin
      stage[0] <= din;
      for (int unsigned i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

endmodule

// File: rtl/frame_window_reader.sv
// Display-side frame-buffer read controller: window test, incremental
// upscaled addressing, and pixel alignment to the RAM read latency.
module frame_window_reader
  import fwr_pkg::*;
#(
  parameter int                DATA_W   = 16,
  parameter int                CNT_W    = 12,
  parameter int                ADDR_W   = 15,
  parameter int                IMG_W    = 160,
  parameter int                IMG_H    = 128,
  parameter int                X_OFS    = 0,
  parameter int                Y_OFS    = 0,
  parameter int                RD_LAT   = 1,
  parameter logic [DATA_W-1:0] BG_COLOR = 16'h0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start,
  input  logic [1:0]            scale,
  input  logic                  data_req,
  input  logic [CNT_W-1:0]      hcount,
  input  logic [CNT_W-1:0]      vcount,
  frame_window_reader_if.master ram,
  output logic [DATA_W-1:0]     pix_data,
  output logic                  pix_de,
  output logic                  pix_in_win,
  output logic                  frame_done
);

  localparam int CMP_W = CNT_W + 3;
  localparam int COL_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
  localparam int ROW_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

  fwr_state_t        state_q, state_d;
  logic [1:0]        scale_lat, shift, s_last, sx, sy;
  logic [COL_W-1:0]  col;
  logic [ROW_W-1:0]  row;
  logic [ADDR_W-1:0] line_base;
  logic [CMP_W-1:0]  hx, vy, x_end, y_end;
  logic              in_win, rd, col_last, line_last, last_pix;
  logic              rd_vld, req_dly;

  // Window bounds, wrap detection and the read qualifier.
  always_comb begin
    shift     = scale_shift(scale_lat);
    s_last    = 2'((3'd1 << shift) - 3'd1);
    hx        = CMP_W'(hcount);
    vy        = CMP_W'(vcount);
    x_end     = CMP_W'(X_OFS) + (CMP_W'(IMG_W) << shift);
    y_end     = CMP_W'(Y_OFS) + (CMP_W'(IMG_H) << shift);
    in_win    = (hx >= CMP_W'(X_OFS)) && (hx < x_end) &&
                (vy >= CMP_W'(Y_OFS)) && (vy < y_end);
    col_last  = (col == COL_LAST) && (sx == s_last);
    line_last = col_last && (sy == s_last);
    last_pix  = line_last && (row == ROW_LAST);
    rd        = data_req && in_win && (state_q == ACTIVE) && !frame_start;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state: frame_start restarts from anywhere; last read finishes.
  always_comb begin
    state_d = state_q;
    if (frame_start)           state_d = ACTIVE;
    else if (rd && last_pix)   state_d = DONE;
  end

  // Incremental counters: sx fastest, then col, sy, row/line_base.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scale_lat <= '0;
      sx        <= '0;
      sy        <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
    end else if (frame_start) begin
      scale_lat <= scale;
      sx        <= '0;
      sy        <= '0;
      col       <= '0;
      row       <= '0;
      line_base <= '0;
    end else if (rd) begin
      if (sx != s_last) begin
        sx <= sx + 2'd1;
      end else begin
        sx <= '0;
        if (col != COL_LAST) begin
          col <= col + COL_W'(1);
        end else begin
          col <= '0;
          if (sy != s_last) begin
            sy <= sy + 2'd1;
          end else begin
            sy <= '0;
            // Holding at the last line keeps the address inside the image.
            if (row != ROW_LAST) begin
              row       <= row + ROW_W'(1);
              line_base <= line_base + ADDR_W'(IMG_W);
            end
          end
        end
      end
    end
  end

  // Registered RAM read port and end-of-frame pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ram.ram_rden   <= 1'b0;
      ram.ram_rdaddr <= '0;
      frame_done     <= 1'b0;
    end else begin
      ram.ram_rden <= rd;
      frame_done   <= rd && last_pix;
      if (rd) ram.ram_rdaddr <= line_base + ADDR_W'(col);
    end
  end

  fwr_delay #(.WIDTH(1), .DEPTH(RD_LAT)) u_rden_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (ram.ram_rden),
    .dout  (rd_vld)
  );

  fwr_delay #(.WIDTH(1), .DEPTH(RD_LAT + 1)) u_req_dly (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (data_req),
    .dout  (req_dly)
  );

  // Output pixel register: RAM data for window reads, background otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_data   <= BG_COLOR;
      pix_de     <= 1'b0;
      pix_in_win <= 1'b0;
    end else begin
      pix_data   <= rd_vld ? ram.ram_q : BG_COLOR;
      pix_de     <= req_dly;
      pix_in_win <= rd_vld;
    end
  end

endmodule

// File: tb/tb_frame_window_reader.sv
// Randomised scoreboard bench for frame_window_reader on a reduced image.
module tb_frame_window_reader;
  import fwr_pkg::*;

  localparam int          DATA_W = 16;
  localparam int          CNT_W  = 8;
  localparam int          ADDR_W = 10;
  localparam int          IMG_W  = 12;
  localparam int          IMG_H  = 6;
  localparam int          X_OFS  = 3;
  localparam int          Y_OFS  = 2;
  localparam int          RD_LAT = 2;
  localparam logic [15:0] BG     = 16'hA5A5;
  localparam int          H_TOT  = 54;
  localparam int          V_TOT  = 28;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              frame_start = 1'b0;
  logic [1:0]        scale = 2'd0;
  logic              data_req = 1'b0;
  logic [CNT_W-1:0]  hcount = '0;
  logic [CNT_W-1:0]  vcount = '0;
  logic [DATA_W-1:0] pix_data;
  logic              pix_de, pix_in_win, frame_done;

  frame_window_reader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) ram_bus ();

  frame_window_reader #(
    .DATA_W(DATA_W), .CNT_W(CNT_W), .ADDR_W(ADDR_W), .IMG_W(IMG_W),
    .IMG_H(IMG_H), .X_OFS(X_OFS), .Y_OFS(Y_OFS), .RD_LAT(RD_LAT),
    .BG_COLOR(BG)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_start(frame_start), .scale(scale),
    .data_req(data_req), .hcount(hcount), .vcount(vcount), .ram(ram_bus),
    .pix_data(pix_data), .pix_de(pix_de), .pix_in_win(pix_in_win),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Two-cycle-latency RAM model.
  logic [DATA_W-1:0] mem [1 << ADDR_W];
  logic [DATA_W-1:0] q1;
  always @(posedge clk) begin
    q1            <= mem[ram_bus.ram_rdaddr];
    ram_bus.ram_q <= q1;
  end

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int t; logic [DATA_W-1:0] d; logic w; } pix_t;
  typedef struct { int t; int a; } rd_t;
  pix_t pix_q[$];
  rd_t  rd_q[$];
  int   done_q[$];
  int   checks = 0, errors = 0;

  task automatic chk(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s got %0d required %0d (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  // Reference model: reads are counted since frame_start; the k-th read's
  // address follows from the upscale factor with plain division.
  bit m_act = 0;
  int m_k = 0, m_s = 1;

  task automatic cycle(input bit fs, input logic [1:0] sc, input bit req,
                       input int h, input int v);
    int  c, per, p, w, a;
    bit  win, rdo;
    pix_t e;
    rd_t  r;
    @(negedge clk);
    frame_start = fs;
    scale       = fs ? sc : 2'($urandom);
    data_req    = req;
    hcount      = CNT_W'(h);
    vcount      = CNT_W'(v);
    c   = cyc;
    rdo = 0;
    win = (h >= X_OFS) && (h < X_OFS + IMG_W * m_s) &&
          (v >= Y_OFS) && (v < Y_OFS + IMG_H * m_s);
    if (fs) begin
      m_act = 1; m_k = 0;
      m_s = (sc == SCALE_2X) ? 2 : (sc == SCALE_4X) ? 4 : 1;
    end else if (req && m_act && win) begin
      per = IMG_W * m_s;
      p   = m_k / per;
      w   = m_k % per;
      a   = (p / m_s) * IMG_W + w / m_s;
      r.t = c + 1; r.a = a;
      rd_q.push_back(r);
      rdo = 1;
      e.t = c + 2 + RD_LAT; e.d = mem[a]; e.w = 1'b1;
      pix_q.push_back(e);
      if (m_k == IMG_W * IMG_H * m_s * m_s - 1) begin
        done_q.push_back(c + 1);
        m_act = 0;
      end
      m_k++;
    end
    if (req && !rdo) begin
      e.t = c + 2 + RD_LAT; e.d = BG; e.w = 1'b0;
      pix_q.push_back(e);
    end
  endtask

  task automatic raster(input int fs_a, input int fs_b, input logic [1:0] sc_a,
                        input logic [1:0] sc_b, input int pct, input int stop_at);
    int  idx = 0;
    bit  fs, req;
    for (int v = 0; v < V_TOT; v++) begin
      for (int h = 0; h < H_TOT; h++) begin
        if (idx == stop_at) return;
        fs  = (idx == fs_a) || (idx == fs_b);
        req = (int'($urandom_range(99)) < pct) || (idx == fs_b);
        cycle(fs, (idx == fs_b) ? sc_b : sc_a, req, h, v);
        idx++;
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ram_rden"},   int'(ram_bus.ram_rden), 0);
    chk({tag, "_ram_rdaddr"}, int'(ram_bus.ram_rdaddr), 0);
    chk({tag, "_pix_data"},   int'(pix_data), int'(BG));
    chk({tag, "_pix_de"},     int'(pix_de), 0);
    chk({tag, "_pix_in_win"}, int'(pix_in_win), 0);
    chk({tag, "_frame_done"}, int'(frame_done), 0);
  endtask

  // Monitor: pops expectations whenever the DUT presents an output.
  pix_t me;
  rd_t  mr;
  always @(negedge clk) begin
    if (rst_n) begin
      while (rd_q.size() > 0 && rd_q[0].t < cyc) begin
        mr = rd_q.pop_front();
        checks++; errors++;
        $display("FAIL rd_missing got none required addr %0d at cycle %0d", mr.a, mr.t);
      end
      while (pix_q.size() > 0 && pix_q[0].t < cyc) begin
        me = pix_q.pop_front();
        checks++; errors++;
        $display("FAIL pix_missing got none required %h at cycle %0d", me.d, me.t);
      end
      while (done_q.size() > 0 && done_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL done_missing got none required pulse at cycle %0d", done_q.pop_front());
      end
      if (ram_bus.ram_rden) begin
        if (rd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL rd_unexpected got addr %0d required no read (cycle %0d)",
                   ram_bus.ram_rdaddr, cyc);
        end else begin
          mr = rd_q.pop_front();
          chk("rd_cycle", cyc, mr.t);
          chk("rd_addr", int'(ram_bus.ram_rdaddr), mr.a);
        end
      end
      if (pix_de) begin
        if (pix_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pix_unexpected got %h required no pixel (cycle %0d)", pix_data, cyc);
        end else begin
          me = pix_q.pop_front();
          chk("pix_cycle", cyc, me.t);
          chk("pix_data", int'(pix_data), int'(me.d));
          chk("pix_in_win", int'(pix_in_win), int'(me.w));
        end
      end
      if (frame_done) begin
        if (done_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL done_unexpected got pulse required none (cycle %0d)", cyc);
        end else begin
          chk("done_cycle", cyc, done_q.pop_front());
        end
      end
    end
  end

  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = DATA_W'($urandom);

    #1 rst_n = 1'b0;
    #1 check_reset_vals("reset");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    raster(-1, -1, SCALE_1X, SCALE_1X, 100, -1);          // idle: background only
    raster(0, -1, SCALE_1X, SCALE_1X, 100, -1);           // full 1x frame
    raster(-1, -1, SCALE_1X, SCALE_1X, 100, -1);          // after done, no restart
    raster(0, -1, SCALE_2X, SCALE_2X, 100, -1);
    raster(0, -1, SCALE_4X, SCALE_4X, 100, -1);
    raster(0, -1, 2'd3, 2'd3, 100, -1);                   // encoding 3 acts as 1x
    raster(0, 4 * H_TOT + 8, SCALE_2X, SCALE_1X, 100, -1); // restart mid-frame
    raster(0, -1, SCALE_4X, SCALE_4X, 70, -1);            // gapped requests
    raster(0, -1, SCALE_1X, SCALE_1X, 100, 5 * H_TOT + 7); // stop mid-line

    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 check_reset_vals("midreset");
    pix_q.delete(); rd_q.delete(); done_q.delete();
    m_act = 0;
    data_req = 1'b0; frame_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    raster(-1, -1, SCALE_1X, SCALE_1X, 100, -1);          // idle after reset
    repeat (10) cycle(1'b0, SCALE_1X, 1'b0, 0, 0);

    chk("rd_queue_left", rd_q.size(), 0);
    chk("pix_queue_left", pix_q.size(), 0);
    chk("done_queue_left", done_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
